// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields into a word with range check.
// Optional ENC_ERRCNT_EN adds a saturating count of emitted error words.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int          ERRCNT_W  = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iClear,
  input  logic        iValid,
  output logic        oReady,
  input  logic [6:0]  iOpcode,
  input  logic [4:0]  iRd,
  input  logic [4:0]  iRs1,
  input  logic [4:0]  iRs2,
  input  logic [2:0]  iFunct3,
  input  logic [6:0]  iFunct7,
  input  logic [31:0] iImm,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oInstr,
  output logic [31:0] oAddr,
  output logic        oErr
`ifdef ENC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] oErrCount
`endif
);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_RTYPE  = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  logic        s1_valid;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;

  logic        s2_valid;
  logic [31:0] s2_word;
  logic        s2_err;
  logic [31:0] addr;

  logic        s2_en;
  logic        xfer_out;
  logic        flush;

  logic        is_r;
  logic        is_sh;
  logic        is_i;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;

  logic        i_ok;
  logic        b_ok;
  logic        j_ok;
  logic        u_ok;
  logic        sh_ok;

  logic [31:0] word;
  logic        err;

  assign flush    = iRST | iClear;
  assign s2_en    = ~s2_valid | iReady;
  assign oReady   = ~s1_valid | s2_en;
  assign xfer_out = s2_valid & iReady;

  assign oValid = s2_valid;
  assign oInstr = s2_word;
  assign oErr   = s2_err;
  assign oAddr  = addr;

  assign is_r  = s1_op == OPC_RTYPE;
  assign is_sh = (s1_op == OPC_OPIMM)
               & (s1_f3[1:0] == 2'b01);
  assign is_i  = ((s1_op == OPC_LOAD)
               | (s1_op == OPC_OPIMM)
               | (s1_op == OPC_JALR)) & ~is_sh;
  assign is_s  = s1_op == OPC_STORE;
  assign is_b  = s1_op == OPC_BRANCH;
  assign is_u  = (s1_op == OPC_LUI)
               | (s1_op == OPC_AUIPC);
  assign is_j  = s1_op == OPC_JAL;

  // A value fits N signed bits when the bits above N-1 are a pure sign run.
  assign i_ok  = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
  assign b_ok  = ((&s1_imm[31:12]) | ~(|s1_imm[31:12]))
               & ~s1_imm[0];
  assign j_ok  = ((&s1_imm[31:20]) | ~(|s1_imm[31:20]))
               & ~s1_imm[0];
  assign u_ok  = ~(|s1_imm[11:0]);
  assign sh_ok = ~(|s1_imm[31:5]);

  always_comb begin
    word = {25'b0, s1_op};
    err  = 1'b1;
    unique case (1'b1)
      is_r: begin
        word = {s1_f7, s1_rs2, s1_rs1,
                s1_f3, s1_rd, s1_op};
        err  = 1'b0;
      end
      is_sh: begin
        word = {s1_f7, s1_imm[4:0], s1_rs1,
                s1_f3, s1_rd, s1_op};
        err  = ~sh_ok;
      end
      is_i: begin
        word = {s1_imm[11:0], s1_rs1,
                s1_f3, s1_rd, s1_op};
        err  = ~i_ok;
      end
      is_s: begin
        word = {s1_imm[11:5], s1_rs2, s1_rs1,
                s1_f3, s1_imm[4:0], s1_op};
        err  = ~i_ok;
      end
      is_b: begin
        word = {s1_imm[12], s1_imm[10:5],
                s1_rs2, s1_rs1, s1_f3,
                s1_imm[4:1], s1_imm[11], s1_op};
        err  = ~b_ok;
      end
      is_u: begin
        word = {s1_imm[31:12], s1_rd, s1_op};
        err  = ~u_ok;
      end
      is_j: begin
        word = {s1_imm[20], s1_imm[10:1],
                s1_imm[11], s1_imm[19:12],
                s1_rd, s1_op};
        err  = ~j_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_word  <= '0;
      s2_err   <= 1'b0;
      addr     <= BASE_ADDR;
    end else begin
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_word <= word;
          s2_err  <= err;
        end
      end
      if (oReady) s1_valid <= iValid;
      if (xfer_out) addr <= addr + 32'd4;
    end
  end

  always_ff @(posedge iCLK) begin
    if (oReady & iValid) begin
      s1_op  <= iOpcode;
      s1_rd  <= iRd;
      s1_rs1 <= iRs1;
      s1_rs2 <= iRs2;
      s1_f3  <= iFunct3;
      s1_f7  <= iFunct7;
      s1_imm <= iImm;
    end
  end

`ifdef ENC_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt;

  assign oErrCount = errcnt;

  always_ff @(posedge iCLK) begin
    if (flush) begin
      errcnt <= '0;
    end else if (xfer_out & s2_err & ~(&errcnt)) begin
      errcnt <= errcnt + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases plus random traffic
// checked against a spec-level encoding model and address tracker.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0040_0000;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic        e;
    logic [31:0] w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        ivalid;
  logic        oready;
  logic [6:0]  d_op;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [2:0]  d_f3;
  logic [6:0]  d_f7;
  logic [31:0] d_imm;
  logic        ovalid;
  logic        ready;
  logic [31:0] oinstr;
  logic [31:0] oaddr;
  logic        oerr;
  logic        dir_ready;
  logic        rnd_ready;
  logic        rnd_bp;

`ifdef ENC_ERRCNT_EN
  logic [15:0] errcount;
`endif

  int checks = 0;
  int errors = 0;

  exp_t        q[$];
  logic [31:0] exp_addr;
  int          exp_ec;

  always #5 clk = ~clk;

  assign ready = rnd_bp ? rnd_ready : dir_ready;

  instr_encoder dut (
    .iCLK    (clk),
    .iRST    (rst),
    .iClear  (clr),
    .iValid  (ivalid),
    .oReady  (oready),
    .iOpcode (d_op),
    .iRd     (d_rd),
    .iRs1    (d_rs1),
    .iRs2    (d_rs2),
    .iFunct3 (d_f3),
    .iFunct7 (d_f7),
    .iImm    (d_imm),
    .oValid  (ovalid),
    .iReady  (ready),
    .oInstr  (oinstr),
    .oAddr   (oaddr),
    .oErr    (oerr)
`ifdef ENC_ERRCNT_EN
    ,
    .oErrCount (errcount)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Encoding straight from the format tables, ranges as integers.
  function automatic exp_t model(input logic [6:0] op,
                                 input logic [4:0] a_rd,
                                 input logic [4:0] a_rs1,
                                 input logic [4:0] a_rs2,
                                 input logic [2:0] a_f3,
                                 input logic [6:0] a_f7,
                                 input logic [31:0] im);
    longint v;
    exp_t   r;
    v   = longint'($signed(im));
    r.e = 1'b0;
    r.w = '0;
    case (op)
      OP_R:
        r.w = {a_f7, a_rs2, a_rs1, a_f3, a_rd, op};
      OP_LOAD, OP_JALR: begin
        r.w = {im[11:0], a_rs1, a_f3, a_rd, op};
        r.e = (v < -2048) || (v > 2047);
      end
      OP_OPIMM: begin
        if (a_f3 == 3'b001 || a_f3 == 3'b101) begin
          r.w = {a_f7, im[4:0], a_rs1, a_f3, a_rd, op};
          r.e = (v < 0) || (v > 31);
        end else begin
          r.w = {im[11:0], a_rs1, a_f3, a_rd, op};
          r.e = (v < -2048) || (v > 2047);
        end
      end
      OP_STORE: begin
        r.w = {im[11:5], a_rs2, a_rs1, a_f3, im[4:0], op};
        r.e = (v < -2048) || (v > 2047);
      end
      OP_BRANCH: begin
        r.w = {im[12], im[10:5], a_rs2, a_rs1, a_f3,
               im[4:1], im[11], op};
        r.e = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      OP_LUI, OP_AUIPC: begin
        r.w = {im[31:12], a_rd, op};
        r.e = (v % 4096) != 0;
      end
      OP_JAL: begin
        r.w = {im[20], im[10:1], im[11], im[19:12], a_rd, op};
        r.e = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: begin
        r.w = {25'b0, op};
        r.e = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Output monitor: each transfer must match the oldest accepted request.
  always @(negedge clk) begin
    exp_t e;
    if (rst || clr) begin
      q.delete();
      exp_addr = BASE;
      exp_ec   = 0;
    end else if (ovalid && ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(ovalid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("out_instr", oinstr, e.w);
        chk("out_err", 32'(oerr), 32'(e.e));
        chk("out_addr", oaddr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        if (e.e && exp_ec < 65535) exp_ec++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [6:0] op,
                      input logic [4:0] a_rd,
                      input logic [4:0] a_rs1,
                      input logic [4:0] a_rs2,
                      input logic [2:0] a_f3,
                      input logic [6:0] a_f7,
                      input logic [31:0] im);
    int n;
    n      = 0;
    d_op   = op;
    d_rd   = a_rd;
    d_rs1  = a_rs1;
    d_rs2  = a_rs2;
    d_f3   = a_f3;
    d_f7   = a_f7;
    d_imm  = im;
    ivalid = 1'b1;
    @(negedge clk);
    while (!oready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!oready) begin
      chk("accept_timeout", 32'(oready), 32'd1);
      ivalid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      q.push_back(model(op, a_rd, a_rs1, a_rs2, a_f3, a_f7, im));
      ivalid = 1'b0;
    end
  endtask

  task automatic one(input string tag,
                     input logic [6:0] op,
                     input logic [4:0] a_rd,
                     input logic [4:0] a_rs1,
                     input logic [4:0] a_rs2,
                     input logic [2:0] a_f3,
                     input logic [6:0] a_f7,
                     input logic [31:0] im,
                     input logic [31:0] ew,
                     input logic ee);
    send(op, a_rd, a_rs1, a_rs2, a_f3, a_f7, im);
    chk({tag, "_lat1"}, 32'(ovalid), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(ovalid), 32'd1);
    chk({tag, "_instr"}, oinstr, ew);
    chk({tag, "_err"}, 32'(oerr), 32'(ee));
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  function automatic logic [31:0] rnd_imm();
    int          bnd[18];
    logic [31:0] r;
    bnd = '{-2049, -2048, 2047, 2048, -4097, -4096,
            4094, 4095, 4096, -1048577, -1048576,
            1048574, 1048575, 1048576, 31, 32, 0, -1};
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 32'(int'($urandom_range(0, 80)) - 40);
      1: return 32'(bnd[$urandom_range(0, 17)]);
      2: return r;
      3: return r & 32'hFFFF_F000;
      4: return {{11{r[20]}}, r[20:1], 1'b0};
      default: return 32'(int'($urandom_range(0, 8191)) - 4096);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops[11];
    ops = '{OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_R,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, 7'h7F, 7'h00};
    rst = 1'b1; clr = 1'b0; ivalid = 1'b0;
    d_op = '0; d_rd = '0; d_rs1 = '0; d_rs2 = '0;
    d_f3 = '0; d_f7 = '0; d_imm = '0;
    dir_ready = 1'b1; rnd_bp = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ovalid), 32'd0);
    chk("rst_instr", oinstr, 32'd0);
    chk("rst_err", 32'(oerr), 32'd0);
    chk("rst_addr", oaddr, BASE);
    chk("rst_ready", 32'(oready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    one("addi", OP_OPIMM, 5, 6, 0, 0, 0, 32'hFFFF_FFFF,
        32'hFFF3_0293, 1'b0);
    chk("addi_addr", oaddr, BASE);
    one("beq8", OP_BRANCH, 0, 1, 2, 0, 0, 32'd8,
        32'h0020_8463, 1'b0);
    one("beq3", OP_BRANCH, 0, 1, 2, 0, 0, 32'd3,
        32'h0020_8163, 1'b1);
    one("beq4096", OP_BRANCH, 0, 1, 2, 0, 0, 32'd4096,
        32'h8020_8063, 1'b1);

    pulse_clr();
    one("jal", OP_JAL, 1, 0, 0, 0, 0, 32'd2048,
        32'h0010_00EF, 1'b0);
    one("lui", OP_LUI, 10, 0, 0, 0, 0, 32'h1234_5000,
        32'h1234_5537, 1'b0);
    chk("lui_addr", oaddr, 32'h0040_0004);
    one("slli", OP_OPIMM, 3, 4, 0, 3'b001, 0, 32'd40,
        32'h0082_1193, 1'b1);
    one("unk", 7'h7F, 31, 31, 31, 3'd7, 7'h7F, 32'hFFFF_FFFF,
        32'h0000_007F, 1'b1);
    @(posedge clk);
    #1;
`ifdef ENC_ERRCNT_EN
    chk("errcount2", 32'(errcount), 32'd2);
`endif
    wait_empty();

    pulse_clr();
    dir_ready = 1'b0;
    send(OP_R, 1, 2, 3, 0, 7'h20, 32'h0);
    send(OP_STORE, 0, 2, 5, 3'd2, 0, 32'hFFFF_FFFC);
    d_op = OP_AUIPC; d_rd = 7; d_imm = 32'h0000_1000;
    ivalid = 1'b1;
    @(negedge clk);
    chk("bp_ready", 32'(oready), 32'd0);
    chk("bp_hold", oinstr, 32'h4031_00B3);
    chk("bp_addr", oaddr, BASE);
    @(negedge clk);
    chk("bp_hold2", oinstr, 32'h4031_00B3);
    chk("bp_ready2", 32'(oready), 32'd0);
    @(posedge clk);
    #1;
    dir_ready = 1'b1;
    send(OP_AUIPC, 7, 0, 0, 0, 0, 32'h0000_1000);
    wait_empty();
    chk("bp_next_addr", oaddr, 32'h0040_000C);

    dir_ready = 1'b0;
    send(OP_LUI, 2, 0, 0, 0, 0, 32'hABCD_E000);
    send(OP_JAL, 3, 0, 0, 0, 0, 32'd16);
    d_op = OP_LOAD; d_rd = 9; d_imm = 32'd4;
    ivalid = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    ivalid = 1'b0;
    chk("clr_valid", 32'(ovalid), 32'd0);
    chk("clr_addr", oaddr, BASE);
`ifdef ENC_ERRCNT_EN
    chk("clr_errcount", 32'(errcount), 32'd0);
`endif
    dir_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("clr_idle", 32'(ovalid), 32'd0);

    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", 32'(ovalid), 32'd0);
        chk("midrst_addr", oaddr, BASE);
      end
      send(ops[$urandom_range(0, 10)],
           5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), rnd_imm());
    end
    wait_empty();
    rnd_bp = 1'b0;
    @(posedge clk);
    #1;
`ifdef ENC_ERRCNT_EN
    chk("final_errcount", 32'(errcount), 32'(exp_ec));
`endif
    chk("final_addr", oaddr, exp_addr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate-generation path: packs opcode, register fields, funct fields and a 32-bit immediate into a RV32I instruction word.
- Checks that the immediate is representable in the selected format.
- Two-stage valid/ready pipeline. Each emitted word carries a sequential instruction-memory write address.
- Used by the program loader and the self-test sequencer to write instructions into instruction memory.

Parameters:
BASE_ADDR, 32'h0040_0000, address attached to the first emitted word after reset/clear
ERRCNT_W, 16, width of the error counter (only used with ENC_ERRCNT_EN)

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous active-high reset
iClear  in  1  synchronous flush of pipeline and address counter
iValid  in  1  input request valid
oReady  out  1  encoder can accept input this cycle
iOpcode  in  7  OPC_* constant from Parametros.v
iRd  in  5  destination register
iRs1  in  5  source register 1
iRs2  in  5  source register 2
iFunct3  in  3  funct3
iFunct7  in  7  funct7
iImm  in  32  full-value signed immediate (byte offset, not pre-shifted)
oValid  out  1  output word valid
iReady  in  1  downstream accepts output
oInstr  out  32  encoded instruction
oAddr  out  32  write address for oInstr
oErr  out  1  immediate not representable, or unknown opcode

Behaviour:
- Reset: oValid=0, oInstr=0, oErr=0, oAddr=BASE_ADDR, both stage valids=0.
- Handshakes:
  - Input transfer occurs on iValid&oReady. Output transfer occurs on oValid&iReady.
  - oReady = !s1_valid | !s2_valid | iReady. This allows full-throughput streaming; both stages fill while iReady=0.
  - Outputs hold stable while oValid=1 and iReady=0.
- Pipeline:
  - S1 registers the inputs and computes format class and range error.
  - S2 registers the assembled word and the error flag.
  - Latency is 2 cycles from accept to oValid when unstalled. Order is preserved with no loss or duplication.
- Format class by opcode:
  - R: OPC_RTYPE.
  - I: OPC_LOAD, OPC_OPIMM, OPC_JALR.
  - S: OPC_STORE.
  - B: OPC_BRANCH.
  - U: OPC_LUI, OPC_AUIPC.
  - J: OPC_JAL.
- Packing by format:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- OPIMM shifts (funct3=001 or 101): bits[31:25]=iFunct7, bits[24:20]=imm[4:0]. Legal imm is 0..31.
- Range errors:
  - I/S: imm outside -2048..2047.
  - B: outside -4096..4094, or imm[0]=1.
  - J: outside -1048576..1048574, or imm[0]=1.
  - U: imm[11:0]!=0.
  - R: never (iImm ignored).
  - On error the word is still emitted with the truncated fields, and oErr=1 for that word only.
- Unknown opcode: oInstr = {25'b0, iOpcode}, oErr=1.
- Address:
  - oAddr is the address of the word currently presented.
  - The counter advances by 4 on each output transfer and wraps modulo 2^32.
- iClear:
  - Same cycle effect as reset on stage valids and oAddr.
  - Clear wins over a simultaneous input accept (input dropped; oReady not gated).
  - An output handshake in that cycle is discarded.
- iRST takes effect mid-stream identically to iClear. All in-flight words are lost.

Optional Feature:
- Macro: ENC_ERRCNT_EN.
- Defined:
  - Adds port oErrCount (out, ERRCNT_W) counting output transfers with oErr=1.
  - Saturates at all-ones. Cleared by iRST and iClear.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ADDI: OPIMM, rd=5, rs1=6, f3=0, imm=32'hFFFF_FFFF -> oInstr=32'hFFF3_0293, oAddr=32'h0040_0000, oErr=0, oValid 2 cycles after accept.
- BEQ: BRANCH, rs1=1, rs2=2, f3=0, imm=8 -> 32'h0020_8463, oErr=0. Same with imm=3 -> oErr=1. With imm=4096 -> oErr=1.
- JAL: rd=1, imm=2048 -> 32'h0010_00EF. Then LUI rd=10, imm=32'h1234_5000 -> 32'h1234_5537 with oAddr=32'h0040_0004.
- Backpressure: iReady=0 while 3 requests are offered -> oReady drops after 2 accepts. Release iReady -> 3 words emitted in order at 0x0040_0000/04/08.
- SLLI: f3=001, f7=0, imm=40 -> oErr=1. Unknown opcode 7'h7F -> oInstr=32'h0000_007F, oErr=1. With ENC_ERRCNT_EN -> oErrCount=2.
- iClear asserted with iValid=1 and both stages full -> next cycle oValid=0, oAddr=BASE_ADDR, dropped input never emitted.
